data_tx_framed: RTL and testbench

Parametrised multi-lane frame serializer for the frontend data link. Accepts fixed-length words over a standard valid/ready handshake into a one-entry holding buffer. Emits each word on LINES parallel wires as START code, data chunks and an optional XOR-checksum trailer chunk, and fills all gaps with IDLE code so the receiver stays phase-locked. Sits between the frontend event packer and the physical output lines.

---
 rtl/data_link_pkg.sv | 41 ++++
 rtl/data_tx_chunk_shift.sv | 43 ++++
 rtl/data_tx_framed.sv | 148 ++++++++++++++
 tb/tb_data_tx_framed.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/data_link_pkg.sv
// Shared line-code generators, FSM encoding and padding helpers for the framed data link.
// Combinational helpers only; no latency and no backpressure involved.
package data_link_pkg;

  localparam int CODE_MAX_W = 1024;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_TRAIL = 2'd3
  } tx_state_e;

  function automatic int length_nxt(input int length, input int chunk_len);
    return ((length + chunk_len - 1) / chunk_len) * chunk_len;
  endfunction

  function automatic int nchunk(input int length, input int chunk_len);
    return length_nxt(length, chunk_len) / chunk_len;
  endfunction

  // Codes are right-aligned; clock 0 of the chunk occupies the top LINES bits.
  function automatic logic [CODE_MAX_W-1:0] idle_code(input int lines, input int clk_per_chunk);
    logic [CODE_MAX_W-1:0] c;
    c = '0;
    for (int k = 0; k < clk_per_chunk; k++)
      for (int l = 0; l < lines; l++)
        c[(clk_per_chunk - 1 - k) * lines + l] = (2 * k < clk_per_chunk);
    return c;
  endfunction

  function automatic logic [CODE_MAX_W-1:0] start_code(input int lines, input int clk_per_chunk);
    logic [CODE_MAX_W-1:0] c;
    c = '0;
    for (int k = 0; k < clk_per_chunk; k++)
      for (int l = 0; l < lines; l++)
        c[(clk_per_chunk - 1 - k) * lines + l] = (k % 2 == 0);
    return c;
  endfunction

endpackage

// File: rtl/data_tx_chunk_shift.sv
// Free-running chunk timer plus output chunk shift register; boundary strobes on the last clock.
// d is the registered top slice; reloads from load_dat at each boundary, never stalls.
module data_tx_chunk_shift
  import data_link_pkg::*;
#(
  parameter int LINES         = 3,
  parameter int CLK_PER_CHUNK = 4,
  localparam int CHUNK_LEN    = LINES * CLK_PER_CHUNK
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [CHUNK_LEN-1:0] load_dat,
  output logic                 boundary,
  output logic [LINES-1:0]     d
);

  localparam int TMR_W = $clog2(CLK_PER_CHUNK);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(CLK_PER_CHUNK - 1);
  localparam logic [CODE_MAX_W-1:0] IDLE_FULL = idle_code(LINES, CLK_PER_CHUNK);
  localparam logic [CHUNK_LEN-1:0] IDLE_CODE = IDLE_FULL[CHUNK_LEN-1:0];

  logic [TMR_W-1:0]     timer_q, timer_d;
  logic [CHUNK_LEN-1:0] shift_q, shift_d;

  always_comb begin
    boundary = (timer_q == TMR_LAST);
    timer_d  = boundary ? '0 : timer_q + TMR_W'(1);
    shift_d  = boundary ? load_dat : (shift_q << LINES);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      timer_q <= '0;
      shift_q <= IDLE_CODE;
    end else begin
      timer_q <= timer_d;
      shift_q <= shift_d;
    end
  end

  assign d = shift_q[CHUNK_LEN-1 -: LINES];

endmodule

// File: rtl/data_tx_framed.sv
// Serializes words as START, MSB-first data chunks and optional XOR trailer, IDLE code in gaps.
// Start latency 1..CLK_PER_CHUNK+1 clocks; one-entry buffer, ready low while it holds a word.
module data_tx_framed
  import data_link_pkg::*;
#(
  parameter int LENGTH        = 128,
  parameter int LINES         = 3,
  parameter int CLK_PER_CHUNK = 4,
  parameter int CHK_EN        = 1,
  parameter int CNT_W         = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              valid,
  output logic              ready,
  input  logic [LENGTH-1:0] data_in,
  output logic              idle,
  output logic [CNT_W-1:0]  frames_sent,
  output logic [LINES-1:0]  d
);

  localparam int CHUNK_LEN = CLK_PER_CHUNK * LINES;
  localparam int LEN_NXT   = length_nxt(LENGTH, CHUNK_LEN);
  localparam int NCHUNK    = nchunk(LENGTH, CHUNK_LEN);
  localparam int PAD       = LEN_NXT - LENGTH;
  localparam int CIDX_W    = $clog2(NCHUNK + 1);
  localparam logic [CIDX_W-1:0] NCHUNK_C = CIDX_W'(NCHUNK);
  localparam logic [CODE_MAX_W-1:0] IDLE_FULL  = idle_code(LINES, CLK_PER_CHUNK);
  localparam logic [CODE_MAX_W-1:0] START_FULL = start_code(LINES, CLK_PER_CHUNK);
  localparam logic [CHUNK_LEN-1:0] IDLE_CODE  = IDLE_FULL[CHUNK_LEN-1:0];
  localparam logic [CHUNK_LEN-1:0] START_CODE = START_FULL[CHUNK_LEN-1:0];

  tx_state_e            state_q, state_d;
  logic [LEN_NXT-1:0]   buf_q, buf_d;
  logic                 buf_full_q, buf_full_d;
  logic [LEN_NXT-1:0]   dsr_q, dsr_d;
  logic [CHUNK_LEN-1:0] csum_q, csum_d;
  logic [CIDX_W-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0]     frames_q, frames_d;

  logic                 boundary;
  logic [CHUNK_LEN-1:0] load_dat;
  logic [CHUNK_LEN-1:0] chunk_nxt;
  logic                 start_ok;
  logic                 frame_end;
  logic                 launch;

  assign chunk_nxt = dsr_q[LEN_NXT-1 -: CHUNK_LEN];
  assign start_ok  = buf_full_q & enable;

  always_comb begin
    state_d    = state_q;
    buf_d      = buf_q;
    buf_full_d = buf_full_q;
    dsr_d      = dsr_q;
    csum_d     = csum_q;
    cnt_d      = cnt_q;
    frames_d   = frames_q;
    load_dat   = IDLE_CODE;
    frame_end  = 1'b0;
    launch     = 1'b0;

    // load_dat is the chunk for the state being entered at this boundary.
    if (boundary) begin
      unique case (state_q)
        ST_IDLE: launch = start_ok;
        ST_START: begin
          state_d  = ST_DATA;
          load_dat = chunk_nxt;
          dsr_d    = dsr_q << CHUNK_LEN;
          csum_d   = chunk_nxt;
          cnt_d    = CIDX_W'(1);
        end
        ST_DATA: begin
          if (cnt_q != NCHUNK_C) begin
            load_dat = chunk_nxt;
            dsr_d    = dsr_q << CHUNK_LEN;
            csum_d   = csum_q ^ chunk_nxt;
            cnt_d    = cnt_q + CIDX_W'(1);
          end else if (CHK_EN != 0) begin
            state_d  = ST_TRAIL;
            load_dat = csum_q;
          end else begin
            frame_end = 1'b1;
          end
        end
        ST_TRAIL: frame_end = 1'b1;
        default:  state_d = ST_IDLE;
      endcase

      if (frame_end) begin
        frames_d = frames_q + CNT_W'(1);
        launch   = start_ok;
        state_d  = ST_IDLE;
      end

      if (launch) begin
        state_d    = ST_START;
        load_dat   = START_CODE;
        dsr_d      = buf_q;
        buf_full_d = 1'b0;
      end
    end

    // Unload needs a full buffer and capture needs an empty one, so they never coincide.
    if (valid && !buf_full_q) begin
      buf_d      = LEN_NXT'(data_in) << PAD;
      buf_full_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      buf_q      <= '0;
      buf_full_q <= 1'b0;
      dsr_q      <= '0;
      csum_q     <= '0;
      cnt_q      <= '0;
      frames_q   <= '0;
    end else begin
      state_q    <= state_d;
      buf_q      <= buf_d;
      buf_full_q <= buf_full_d;
      dsr_q      <= dsr_d;
      csum_q     <= csum_d;
      cnt_q      <= cnt_d;
      frames_q   <= frames_d;
    end
  end

  data_tx_chunk_shift #(
    .LINES         (LINES),
    .CLK_PER_CHUNK (CLK_PER_CHUNK)
  ) u_chunk_shift (
    .clk      (clk),
    .rst      (rst),
    .load_dat (load_dat),
    .boundary (boundary),
    .d        (d)
  );

  assign ready       = !buf_full_q;
  assign idle        = (state_q == ST_IDLE);
  assign frames_sent = frames_q;

endmodule

// File: tb/tb_data_tx_framed.sv
// Drives a checksum and a no-checksum serializer with shared timing against a frame-level model.
// Per-clock line, idle, ready and frame-count checks plus constant chunk checks on directed frames.
module tb_data_tx_framed;

  localparam int L    = 3;
  localparam int CPC  = 4;
  localparam int LEN  = 24;
  localparam int CL   = L * CPC;
  localparam int NCH  = 2;
  localparam logic [CL-1:0] IDLE_C  = 12'hFC0;
  localparam logic [CL-1:0] START_C = 12'hE38;

  logic            clk;
  logic            rst;
  logic            enable;
  logic            valid_v  [2];
  logic [LEN-1:0]  data_v   [2];
  logic            ready_v  [2];
  logic            idle_v   [2];
  logic [15:0]     frames_v [2];
  logic [L-1:0]    d_v      [2];

  int n_vec;
  int n_err;

  data_tx_framed #(.LENGTH(LEN), .LINES(L), .CLK_PER_CHUNK(CPC), .CHK_EN(1), .CNT_W(16)) u_dut_chk (
    .clk(clk), .rst(rst), .enable(enable), .valid(valid_v[0]), .ready(ready_v[0]),
    .data_in(data_v[0]), .idle(idle_v[0]), .frames_sent(frames_v[0]), .d(d_v[0])
  );

  data_tx_framed #(.LENGTH(LEN), .LINES(L), .CLK_PER_CHUNK(CPC), .CHK_EN(0), .CNT_W(16)) u_dut_nochk (
    .clk(clk), .rst(rst), .enable(enable), .valid(valid_v[1]), .ready(ready_v[1]),
    .data_in(data_v[1]), .idle(idle_v[1]), .frames_sent(frames_v[1]), .d(d_v[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: frame as a list of chunks, position within it, one-word buffer.
  int             m_ph;
  bit             m_act   [2];
  int             m_pos   [2];
  int             m_flen  [2];
  logic [CL-1:0]  m_frame [2][0:3];
  bit             m_full  [2];
  logic [LEN-1:0] m_buf   [2];
  logic [15:0]    m_frames[2];

  logic [LEN-1:0] wq [2][$];
  logic [CL-1:0]  cq [2][$];
  logic [CL-1:0]  acc[2];
  bit             gate[2];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    m_ph = 0;
    for (int k = 0; k < 2; k++) begin
      m_act[k] = 0; m_pos[k] = 0; m_flen[k] = 0;
      m_full[k] = 0; m_buf[k] = '0; m_frames[k] = '0;
    end
  endtask

  task automatic model_step(input int k);
    bit xfer;
    logic [CL-1:0] c;
    xfer = valid_v[k] && !m_full[k];
    if (m_ph == CPC - 1) begin
      if (m_act[k] && m_pos[k] < m_flen[k] - 1) begin
        m_pos[k]++;
      end else begin
        if (m_act[k]) m_frames[k]++;
        m_act[k] = 0;
        if (m_full[k] && enable) begin
          m_frame[k][0] = START_C;
          c = '0;
          for (int i = 0; i < NCH; i++) begin
            m_frame[k][1 + i] = CL'(m_buf[k] >> (CL * (NCH - 1 - i)));
            c ^= m_frame[k][1 + i];
          end
          m_frame[k][1 + NCH] = c;
          m_flen[k] = 1 + NCH + ((k == 0) ? 1 : 0);
          m_pos[k]  = 0;
          m_act[k]  = 1;
          m_full[k] = 0;
        end
      end
    end
    if (xfer) begin
      m_full[k] = 1;
      m_buf[k]  = data_v[k];
      void'(wq[k].pop_front());
    end
  endtask

  task automatic check_outputs();
    logic [CL-1:0] ch;
    for (int k = 0; k < 2; k++) begin
      ch = m_act[k] ? m_frame[k][m_pos[k]] : IDLE_C;
      check_val((k == 0) ? "d_chk" : "d_nochk", 32'(d_v[k]), 32'(ch[CL - 1 - L * m_ph -: L]));
      check_val((k == 0) ? "idle_chk" : "idle_nochk", 32'(idle_v[k]), 32'(!m_act[k]));
      check_val((k == 0) ? "ready_chk" : "ready_nochk", 32'(ready_v[k]), 32'(!m_full[k]));
      check_val((k == 0) ? "frames_chk" : "frames_nochk", 32'(frames_v[k]), 32'(m_frames[k]));
      acc[k] = {acc[k][CL-L-1:0], d_v[k]};
      if (m_ph == CPC - 1) cq[k].push_back(acc[k]);
    end
  endtask

  task automatic tick();
    for (int k = 0; k < 2; k++) begin
      valid_v[k] = gate[k] && (wq[k].size() != 0);
      data_v[k]  = (wq[k].size() != 0) ? wq[k][0] : '0;
    end
    @(posedge clk);
    for (int k = 0; k < 2; k++) model_step(k);
    m_ph = (m_ph + 1) % CPC;
    @(negedge clk);
    check_outputs();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      valid_v[k] = 1'b0; gate[k] = 1'b1;
      wq[k].delete(); cq[k].delete(); acc[k] = '0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    model_reset();
    rst = 1'b1;
    check_outputs();
  endtask

  // Locates the first non-IDLE chunk; returns -1 if fewer than 'need' chunks follow it.
  function automatic int find_start(input int k, input int need);
    int j;
    j = -1;
    for (int i = 0; i < cq[k].size(); i++)
      if (j < 0 && cq[k][i] != IDLE_C) j = i;
    if (j >= 0 && j + need >= cq[k].size()) j = -1;
    return j;
  endfunction

  task automatic frame_scan(input logic [LEN-1:0] w);
    int j;
    do_reset();
    wq[0].push_back(w); wq[1].push_back(w);
    repeat (28) tick();
    for (int k = 0; k < 2; k++) begin
      j = find_start(k, 4);
      check_val("frame_found", 32'(j >= 0), 32'd1);
      if (j >= 0) begin
        check_val("start_code", 32'(cq[k][j]), 32'(START_C));
        check_val("chunk_hi", 32'(cq[k][j + 1]), 32'(w[23:12]));
        check_val("chunk_lo", 32'(cq[k][j + 2]), 32'(w[11:0]));
        if (k == 0) begin
          check_val("trailer", 32'(cq[k][j + 3]), 32'(w[23:12] ^ w[11:0]));
          check_val("post_idle", 32'(cq[k][j + 4]), 32'(IDLE_C));
        end else begin
          check_val("no_trailer", 32'(cq[k][j + 3]), 32'(IDLE_C));
        end
      end
      check_val("one_frame", 32'(frames_v[k]), 32'd1);
    end
  endtask

  initial begin
    int j;
    n_vec = 0; n_err = 0;
    enable = 1'b1;
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      valid_v[k] = 1'b0; data_v[k] = '0; gate[k] = 1'b1; acc[k] = '0;
    end
    #1;
    model_reset();

    // Idle after reset: three IDLE chunks.
    do_reset();
    repeat (12) tick();

    frame_scan(24'hABC123);
    frame_scan(24'h000FFF);

    // Back-to-back words with valid held: second START directly after first frame.
    do_reset();
    for (int k = 0; k < 2; k++) begin
      wq[k].push_back(24'h5A5A5A); wq[k].push_back(24'h0F1E2D);
    end
    repeat (44) tick();
    for (int k = 0; k < 2; k++) begin
      j = find_start(k, 3 + ((k == 0) ? 1 : 0) + 1);
      check_val("b2b_found", 32'(j >= 0), 32'd1);
      if (j >= 0) check_val("b2b_start", 32'(cq[k][j + 3 + ((k == 0) ? 1 : 0)]), 32'(START_C));
      check_val("b2b_frames", 32'(frames_v[k]), 32'd2);
    end

    // enable dropped mid-frame with a second word buffered.
    do_reset();
    for (int k = 0; k < 2; k++) begin
      wq[k].push_back(24'h123456); wq[k].push_back(24'hFEDCBA);
    end
    repeat (10) tick();
    enable = 1'b0;
    repeat (40) tick();
    for (int k = 0; k < 2; k++) begin
      check_val("hold_ready", 32'(ready_v[k]), 32'd0);
      check_val("hold_idle", 32'(idle_v[k]), 32'd1);
      check_val("hold_frames", 32'(frames_v[k]), 32'd1);
    end
    enable = 1'b1;
    repeat (30) tick();

    // Asynchronous reset in the middle of a DATA chunk.
    do_reset();
    wq[0].push_back(24'h777000); wq[1].push_back(24'h777000);
    repeat (10) tick();
    #2;
    rst = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      check_val("arst_d", 32'(d_v[k]), 32'h7);
      check_val("arst_idle", 32'(idle_v[k]), 32'd1);
      check_val("arst_ready", 32'(ready_v[k]), 32'd1);
      check_val("arst_frames", 32'(frames_v[k]), 32'd0);
    end
    do_reset();
    wq[0].push_back(24'h13579B); wq[1].push_back(24'h13579B);
    repeat (30) tick();
    for (int k = 0; k < 2; k++) check_val("refr_frames", 32'(frames_v[k]), 32'd1);

    // Random traffic with random valid gaps and enable changes.
    do_reset();
    for (int t = 0; t < 3000; t++) begin
      for (int k = 0; k < 2; k++) begin
        if ($urandom_range(0, 3) == 0 && wq[k].size() < 2) wq[k].push_back(LEN'($urandom));
        gate[k] = ($urandom_range(0, 3) != 0);
      end
      if (t % 20 == 0) enable = ($urandom_range(0, 9) != 0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
